ps2_key_ctrl: RTL and testbench

// Sequencer between the PS/2 byte receiver and the scancode-to-text decoder.

---
 rtl/ps2_key_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_ctrl
//  Purpose  : Sequencer between the PS/2 byte receiver and the scancode
//             decoder. Parses set-2 make / F0 break / E0 extended sequences,
//             filters typematic repeats and controller status bytes, and
//             emits one write pulse plus scancode per accepted key press.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_key_ctrl #(
  parameter int TIMEOUT_CYC = 1000000,  // cycles a prefix state waits before abort
  parameter int CNT_W       = 20,       // timeout counter width, holds TIMEOUT_CYC-1
  parameter bit REPEAT_EN   = 1'b0      // 1 = pass typematic repeats of the held key
) (
  input  logic       clk,
  input  logic       rst,        // asynchronous, active-low
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_err,
  output logic       write,
  output logic [7:0] data,
  output logic       key_held,
  output logic       sync_err
);

  // Byte values with protocol meaning
  localparam logic [7:0] C_BREAK  = 8'hF0;
  localparam logic [7:0] C_EXT    = 8'hE0;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BREAK     = 2'd1,
    ST_EXT       = 2'd2,
    ST_EXT_BREAK = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       last_code_q, last_code_d;
  logic             key_held_q, key_held_d;
  logic             write_q, write_d;
  logic [7:0]       data_q, data_d;
  logic             sync_err_q, sync_err_d;

  logic             repeat_hit;
  logic             timeout_hit;

  // Pause prefix, BAT result, ack, resend, echo and overrun bytes never
  // reach the decoder; they are dropped while idle.
  function automatic logic is_status(input logic [7:0] b);
    logic r;
    r = 1'b0;
    case (b)
      8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Typematic repeat detection: only meaningful when repeats are suppressed.
  generate
    if (REPEAT_EN) begin : g_repeat_pass
      assign repeat_hit = 1'b0;
    end else begin : g_repeat_block
      assign repeat_hit = key_held_q && (rx_data == last_code_q);
    end
  endgenerate

  // A prefix state has waited its full budget with no byte arriving.
  assign timeout_hit = (state_q != ST_IDLE) && (cnt_q == C_CNT_LAST);

  // Next-state and output decode; priority is rx_err, then rx_valid, then timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_code_d = last_code_q;
    key_held_d  = key_held_q;
    write_d     = 1'b0;
    data_d      = data_q;
    sync_err_d  = 1'b0;

    if (rx_err) begin
      // A corrupted byte may have been part of a sequence; restart parsing.
      state_d    = ST_IDLE;
      cnt_d      = '0;
      sync_err_d = 1'b1;
    end else if (rx_valid) begin
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (rx_data == C_BREAK) begin
            state_d = ST_BREAK;
          end else if (rx_data == C_EXT) begin
            state_d = ST_EXT;
          end else if (is_status(rx_data)) begin
            state_d = ST_IDLE;
          end else if (!repeat_hit) begin
            write_d     = 1'b1;
            data_d      = rx_data;
            last_code_d = rx_data;
            key_held_d  = 1'b1;
          end
        end
        ST_BREAK: begin
          // Releasing an older key while a newer one is held keeps key_held set.
          if (rx_data == last_code_q) begin
            key_held_d = 1'b0;
          end
          state_d = ST_IDLE;
        end
        ST_EXT: begin
          // The decoder has no extended map, so extended makes are dropped.
          if (rx_data == C_BREAK) begin
            state_d = ST_EXT_BREAK;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_EXT_BREAK: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (timeout_hit) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      sync_err_d = 1'b1;
    end else begin
      cnt_d = cnt_q + C_CNT_ONE;
    end
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_code_q <= 8'h00;
      key_held_q  <= 1'b0;
      write_q     <= 1'b0;
      data_q      <= 8'h00;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_code_q <= last_code_d;
      key_held_q  <= key_held_d;
      write_q     <= write_d;
      data_q      <= data_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign write    = write_q;
  assign data     = data_q;
  assign key_held = key_held_q;
  assign sync_err = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_key_ctrl
//  Purpose  : Directed self-checking bench for ps2_key_ctrl. Expected
//             scancodes are queued when stimulus should produce a write and
//             popped when the DUT pulses write.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_key_ctrl;

  logic       clk;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_err;
  logic       write;
  logic [7:0] data;
  logic       key_held;
  logic       sync_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  ps2_key_ctrl #(
    .TIMEOUT_CYC(16),
    .CNT_W      (5),
    .REPEAT_EN  (1'b0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .rx_err  (rx_err),
    .write   (write),
    .data    (data),
    .key_held(key_held),
    .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Each call presents one byte for exactly one clock; consecutive calls are back-to-back.
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: every write pulse must match the oldest expected scancode.
  always @(negedge clk) begin
    if (rst && write) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $error("FAIL unexpected_write: observed data %02h expected no write", data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        assert (data === e) n_pass++;
        else $error("FAIL write_data: observed %02h expected %02h", data, e);
      end
    end
  end

  initial begin
    int lat;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rx_err   = 1'b0;

    // Reset state
    #3;
    check("rst_write", write, 0);
    check("rst_data", data, 8'h00);
    check("rst_key_held", key_held, 0);
    check("rst_sync_err", sync_err, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(1);

    // Single make code
    exp_q.push_back(8'h1C);
    send(8'h1C);
    check("t1_write", write, 1);
    check("t1_data", data, 8'h1C);
    check("t1_key_held", key_held, 1);
    check("t1_sync_err", sync_err, 0);
    idle(1);
    check("t1_write_one_cycle", write, 0);

    // Typematic repeats suppressed, release, press again
    send(8'h1C);
    send(8'h1C);
    idle(2);
    check("t2_repeat_held", key_held, 1);
    send(8'hF0);
    send(8'h1C);
    check("t2_release_held", key_held, 0);
    check("t2_release_nowrite", write, 0);
    check("t2_data_stable", data, 8'h1C);
    idle(1);
    exp_q.push_back(8'h1C);
    send(8'h1C);
    check("t2_second_write", write, 1);
    idle(1);

    // Extended make and break are dropped
    send(8'hE0);
    send(8'h75);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check("t3_ext_held", key_held, 1);
    idle(1);
    exp_q.push_back(8'h32);
    send(8'h32);
    check("t3_data", data, 8'h32);

    // New key while another is held; break of older key keeps key_held
    exp_q.push_back(8'h1C);
    send(8'h1C);
    send(8'hF0);
    send(8'h32);
    check("t3_old_break_held", key_held, 1);
    send(8'hF0);
    send(8'h1C);
    check("t3_new_break_held", key_held, 0);
    idle(1);

    // Status bytes filtered
    send(8'hAA);
    check("t4_aa_sync", sync_err, 0);
    send(8'hFA);
    check("t4_fa_sync", sync_err, 0);
    send(8'hE1);
    send(8'h00);
    send(8'hFF);
    check("t4_status_sync", sync_err, 0);
    check("t4_status_write", write, 0);
    exp_q.push_back(8'h1C);
    send(8'h1C);
    check("t4_write", write, 1);
    send(8'hF0);
    send(8'h1C);
    check("t4_released", key_held, 0);
    idle(1);

    // Timeout of a pending break prefix
    send(8'hF0);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (sync_err) begin
        lat = i;
        break;
      end
    end
    check("t5_timeout_latency", lat, 16);
    idle(1);
    check("t5_sync_pulse_len", sync_err, 0);
    exp_q.push_back(8'h1C);
    send(8'h1C);
    check("t5_write_after_timeout", write, 1);
    check("t5_held", key_held, 1);

    // Byte arriving on the timeout cycle wins over the timeout
    send(8'hF0);
    idle(15);
    send(8'h1C);
    check("t5_byte_wins_sync", sync_err, 0);
    check("t5_byte_wins_release", key_held, 0);
    idle(2);

    // rx_err mid-sequence
    send(8'hE0);
    rx_err = 1'b1;
    idle(1);
    rx_err = 1'b0;
    check("t6_rx_err_sync", sync_err, 1);
    idle(1);
    // after abort the parser is idle, so a plain make is emitted
    exp_q.push_back(8'h4D);
    send(8'h4D);
    check("t6_after_err_write", write, 1);
    send(8'hF0);
    send(8'h4D);
    idle(1);

    // rx_err and rx_valid together: error wins, byte ignored
    rx_err = 1'b1;
    send(8'h2B);
    rx_err = 1'b0;
    check("t6_err_wins_sync", sync_err, 1);
    check("t6_err_wins_nowrite", write, 0);
    check("t6_err_wins_held", key_held, 0);
    idle(1);

    // Asynchronous reset between clock edges
    exp_q.push_back(8'h5A);
    send(8'h5A);
    #6;
    rst = 1'b0;
    #1;
    check("t6_async_write", write, 0);
    check("t6_async_data", data, 8'h00);
    check("t6_async_held", key_held, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(1);

    // Reset discards a pending prefix
    send(8'hE0);
    rst = 1'b0;
    #2 rst = 1'b1;
    idle(1);
    exp_q.push_back(8'h33);
    send(8'h33);
    check("t6_prefix_cleared_write", write, 1);
    idle(3);

    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
